smg_scroll_src: RTL and testbench

//  Upstream digit source for the 4-digit seven-segment driver. Holds a loadable

---
 rtl/smg_scroll_src_pkg.sv | 25 ++
 rtl/smg_tick_gen.sv | 47 ++++
 rtl/smg_scroll_src.sv | 210 +++++++++++++++++++++
 tb/tb_smg_scroll_src.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/smg_scroll_src_pkg.sv
// -----------------------------------------------------------------------------
// smg_scroll_src_pkg
//   Shared definitions for the seven-segment scrolling digit source.
//   - scroll_state_e : message life cycle (EMPTY -> LOAD -> READY <-> RUN)
//   - DIGITS         : width of the visible window in hex digits
//   - NIBBLE_W       : bits per hex digit
//   - state_committed: true once a message has been committed (READY/RUN)
// -----------------------------------------------------------------------------
package smg_scroll_src_pkg;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_RUN   = 2'd3
    } scroll_state_e;

    function automatic logic state_committed(input scroll_state_e s);
        return (s == ST_READY) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/smg_tick_gen.sv
// -----------------------------------------------------------------------------
// smg_tick_gen
//   Free-running divider producing a one-cycle tick every DIV enabled cycles.
//   Also usable as the multiplex-rate divider of the display driver.
// Ports
//   clk     in  : clock, rising edge
//   rst     in  : asynchronous active-high reset, counter -> 0
//   en      in  : count while high, hold while low
//   restart in  : synchronous counter clear (wins over en)
//   tick    out : high in the cycle the counter sits at DIV-1 while enabled
// -----------------------------------------------------------------------------
module smg_tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic restart,
    output logic tick
);

    localparam int unsigned      CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && !restart && (cnt_q == TERM);

endmodule

// File: rtl/smg_scroll_src.sv
// -----------------------------------------------------------------------------
// smg_scroll_src
//   Digit source for the 4-digit seven-segment driver. A message of hex digits
//   is loaded one digit at a time, then a 4-digit window is scrolled across it
//   (wrapping modulo the message length) once every STEP_DIV clocks.
// Ports
//   clk      in  : clock, rising edge
//   rst      in  : asynchronous active-high reset
//   clear    in  : discard message, back to EMPTY (highest priority)
//   wr_en    in  : write wr_digit at the write pointer (EMPTY/LOAD only)
//   wr_digit in  : digit to write
//   wr_last  in  : with wr_en, this digit ends the message
//   run      in  : level, 1 = scroll, 0 = hold window
//   dir      in  : 0 = scroll left (head+1), 1 = scroll right (head-1)
//   data     out : registered window buf[h],buf[h+1],buf[h+2],buf[h+3] (MSB first)
//   len      out : committed message length, 0 when no message
//   ready    out : message committed
//   step     out : one-cycle pulse in the cycle head has just advanced
// -----------------------------------------------------------------------------
module smg_scroll_src
    import smg_scroll_src_pkg::*;
#(
    parameter int unsigned STEP_DIV = 50_000_000,
    parameter int unsigned MAX_LEN  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [3:0]                   wr_digit,
    input  logic                         wr_last,
    input  logic                         run,
    input  logic                         dir,
    output logic [15:0]                  data,
    output logic [$clog2(MAX_LEN+1)-1:0] len,
    output logic                         ready,
    output logic                         step
);

    localparam int unsigned      LEN_W    = $clog2(MAX_LEN + 1);
    localparam int unsigned      ADDR_W   = $clog2(MAX_LEN);
    localparam int unsigned      SUM_W    = LEN_W + 2;
    localparam logic [LEN_W-1:0] LAST_PTR = LEN_W'(MAX_LEN - 1);

    scroll_state_e     state_q;
    scroll_state_e     state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_d;
    logic [LEN_W-1:0]  head_q;
    logic [LEN_W-1:0]  head_d;
    logic [LEN_W-1:0]  wr_ptr_q;
    logic [LEN_W-1:0]  wr_ptr_d;
    logic              step_q;
    logic              step_d;
    logic [15:0]       data_q;
    logic [15:0]       data_d;

    logic [3:0]        msg_q [MAX_LEN];
    logic              msg_we;
    logic [ADDR_W-1:0] msg_waddr;

    logic              tick;
    logic              run_enter;

    // (h + k) mod l for h < l and k <= 3. Three conditional subtractions are
    // enough even for l = 1, where h + k can reach 3 * l.
    function automatic logic [ADDR_W-1:0] wrap_idx(input logic [LEN_W-1:0] h,
                                                   input logic [LEN_W-1:0] l,
                                                   input logic [1:0]       k);
        logic [SUM_W-1:0] v;
        v = {2'b00, h} + {{LEN_W{1'b0}}, k};
        for (int i = 0; i < 3; i++) begin
            if (v >= {2'b00, l}) begin
                v = v - {2'b00, l};
            end
        end
        return v[ADDR_W-1:0];
    endfunction

    function automatic logic [LEN_W-1:0] next_head(input logic [LEN_W-1:0] h,
                                                   input logic [LEN_W-1:0] l,
                                                   input logic             d);
        logic [LEN_W-1:0] last;
        last = l - LEN_W'(1);
        if (d) begin
            return (h == '0) ? last : h - LEN_W'(1);
        end
        return (h == last) ? '0 : h + LEN_W'(1);
    endfunction

    // Derived from registered state and inputs only, so the prescaler restart
    // does not loop back through the next-state logic that consumes tick.
    assign run_enter = (state_q == ST_READY) && run && !clear;

    smg_tick_gen #(
        .DIV (STEP_DIV)
    ) u_step_tick (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == ST_RUN),
        .restart (run_enter),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        head_d    = head_q;
        wr_ptr_d  = wr_ptr_q;
        step_d    = 1'b0;
        msg_we    = 1'b0;
        msg_waddr = wr_ptr_q[ADDR_W-1:0];

        if (clear) begin
            state_d  = ST_EMPTY;
            len_d    = '0;
            head_d   = '0;
            wr_ptr_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (wr_en) begin
                        msg_we    = 1'b1;
                        msg_waddr = '0;
                        wr_ptr_d  = LEN_W'(1);
                        if (wr_last) begin
                            state_d = ST_READY;
                            len_d   = LEN_W'(1);
                            head_d  = '0;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_en) begin
                        msg_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + LEN_W'(1);
                        // A full buffer commits itself, so no write can land
                        // beyond the last slot.
                        if (wr_last || (wr_ptr_q == LAST_PTR)) begin
                            state_d = ST_READY;
                            len_d   = wr_ptr_q + LEN_W'(1);
                            head_d  = '0;
                        end
                    end
                end
                ST_READY: begin
                    if (run) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Dropping run wins over a coincident terminal count.
                    if (!run) begin
                        state_d = ST_READY;
                    end else if (tick) begin
                        step_d = 1'b1;
                        head_d = next_head(head_q, len_q, dir);
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Window follows the registered head, hence one cycle behind head changes.
    always_comb begin
        data_d = '0;
        if (!clear && state_committed(state_q)) begin
            for (int d = 0; d < DIGITS; d++) begin
                data_d[(DIGITS - 1 - d) * NIBBLE_W +: NIBBLE_W] =
                    msg_q[wrap_idx(head_q, len_q, 2'(d))];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            len_q    <= '0;
            head_q   <= '0;
            wr_ptr_q <= '0;
            step_q   <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            step_q   <= step_d;
            data_q   <= data_d;
        end
    end

    // Message storage carries no reset; it is only read once committed.
    always_ff @(posedge clk) begin
        if (msg_we) begin
            msg_q[msg_waddr] <= wr_digit;
        end
    end

    assign data  = data_q;
    assign len   = len_q;
    assign ready = state_committed(state_q);
    assign step  = step_q;

endmodule

// File: tb/tb_smg_scroll_src.sv
// -----------------------------------------------------------------------------
// tb_smg_scroll_src
//   Self-checking bench for smg_scroll_src (STEP_DIV=4, MAX_LEN=16). A message
//   queue model counts cycles spent running and rotates a head index with
//   plain modular arithmetic; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_smg_scroll_src;

    localparam int STEP_DIV = 4;
    localparam int MAX_LEN  = 16;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        clear    = 1'b0;
    logic        wr_en    = 1'b0;
    logic [3:0]  wr_digit = 4'h0;
    logic        wr_last  = 1'b0;
    logic        run      = 1'b0;
    logic        dir      = 1'b0;
    logic [15:0] data;
    logic [4:0]  len;
    logic        ready;
    logic        step;

    int n_checks = 0;
    int n_fail   = 0;

    int          ld[$];
    int          m_q[$];
    bit          m_committed;
    bit          m_running;
    bit          m_step;
    int          m_head;
    int          m_cnt;
    logic [15:0] m_data;

    smg_scroll_src #(
        .STEP_DIV (STEP_DIV),
        .MAX_LEN  (MAX_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .wr_en    (wr_en),
        .wr_digit (wr_digit),
        .wr_last  (wr_last),
        .run      (run),
        .dir      (dir),
        .data     (data),
        .len      (len),
        .ready    (ready),
        .step     (step)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_window(input int h);
        logic [15:0] w;
        int n;
        n = m_q.size();
        w = 16'h0;
        for (int i = 0; i < 4; i++) begin
            w[15 - 4 * i -: 4] = 4'(m_q[(h + i) % n]);
        end
        return w;
    endfunction

    function automatic logic [4:0] model_len();
        return m_committed ? 5'(m_q.size()) : 5'd0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_committed = 1'b0;
        m_running   = 1'b0;
        m_step      = 1'b0;
        m_head      = 0;
        m_cnt       = 0;
        m_data      = 16'h0;
    endtask

    // Applies the inputs seen at a rising edge to the message model.
    task automatic model_edge();
        logic [15:0] nd;
        int n;
        nd = (m_committed && !clear) ? model_window(m_head) : 16'h0;
        m_step = 1'b0;
        if (clear) begin
            m_q.delete();
            m_committed = 1'b0;
            m_running   = 1'b0;
            m_head      = 0;
        end else if (!m_committed) begin
            if (wr_en) begin
                m_q.push_back(int'(wr_digit));
                if (wr_last || m_q.size() == MAX_LEN) begin
                    m_committed = 1'b1;
                    m_head      = 0;
                end
            end
        end else if (!m_running) begin
            if (run) begin
                m_running = 1'b1;
                m_cnt     = 0;
            end
        end else if (!run) begin
            m_running = 1'b0;
        end else begin
            m_cnt++;
            if (m_cnt == STEP_DIV) begin
                n      = m_q.size();
                m_cnt  = 0;
                m_step = 1'b1;
                m_head = dir ? (m_head + n - 1) % n : (m_head + 1) % n;
            end
        end
        m_data = nd;
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        run   = 1'b0;
        wr_en = 1'b0;
        clk_step();
        clear = 1'b0;
    endtask

    task automatic load_msg(input bit use_last);
        for (int i = 0; i < ld.size(); i++) begin
            wr_en    = 1'b1;
            wr_digit = 4'(ld[i]);
            wr_last  = use_last && (i == ld.size() - 1);
            clk_step();
        end
        wr_en   = 1'b0;
        wr_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0000", data);
        end
        n_checks++;
        if (len !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_len: got %0d want 0", len);
        end
        n_checks++;
        if (ready !== 1'b0 || step !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got ready=%b step=%b want 0 0", ready, step);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_scroll_left();
        logic [15:0] exp_w [11];
        int nsteps;
        exp_w = '{16'h1234, 16'h2345, 16'h3456, 16'h4567, 16'h5678, 16'h6789,
                  16'h7890, 16'h8901, 16'h9012, 16'h0123, 16'h1234};
        do_clear();
        ld.delete();
        for (int i = 1; i <= 10; i++) ld.push_back(i % 10);
        dir = 1'b0;
        load_msg(1'b1);
        run = 1'b1;
        clk_step();
        n_checks++;
        if (data !== 16'h1234) begin
            n_fail++;
            $display("FAIL left_first: got %h want 1234", data);
        end
        nsteps = 0;
        for (int c = 1; c <= 44; c++) begin
            clk_step();
            n_checks++;
            if ({data, len, ready, step} !== {m_data, model_len(), m_committed, m_step}) begin
                n_fail++;
                $display("FAIL left_model c=%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, data, len, ready, step, m_data, model_len(), m_committed, m_step);
            end
            if (step) begin
                n_checks++;
                if (c != 4 * (nsteps + 1)) begin
                    n_fail++;
                    $display("FAIL left_step_time: step at cycle %0d want %0d", c, 4 * (nsteps + 1));
                end
                nsteps++;
            end
            if (c >= 5 && c % 4 == 1) begin
                n_checks++;
                if (data !== exp_w[(c - 1) / 4]) begin
                    n_fail++;
                    $display("FAIL left_window c=%0d: got %h want %h", c, data, exp_w[(c - 1) / 4]);
                end
            end
        end
        n_checks++;
        if (nsteps != 11) begin
            n_fail++;
            $display("FAIL left_step_count: got %0d want 11", nsteps);
        end
    endtask

    task automatic test_scroll_right_hold();
        do_clear();
        ld.delete();
        for (int i = 1; i <= 10; i++) ld.push_back(i % 10);
        dir = 1'b1;
        load_msg(1'b1);
        run = 1'b1;
        clk_step();
        n_checks++;
        if (data !== 16'h1234) begin
            n_fail++;
            $display("FAIL right_first: got %h want 1234", data);
        end
        for (int c = 1; c <= 25; c++) begin
            if (c == 10) run = 1'b0;
            if (c == 20) run = 1'b1;
            clk_step();
            n_checks++;
            if ({data, len, ready, step} !== {m_data, model_len(), m_committed, m_step}) begin
                n_fail++;
                $display("FAIL right_model c=%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, data, len, ready, step, m_data, model_len(), m_committed, m_step);
            end
            if (c == 5) begin
                n_checks++;
                if (data !== 16'h0123) begin
                    n_fail++;
                    $display("FAIL right_win1: got %h want 0123", data);
                end
            end
            if (c >= 9 && c <= 24) begin
                n_checks++;
                if (data !== 16'h9012) begin
                    n_fail++;
                    $display("FAIL right_hold c=%0d: got %h want 9012", c, data);
                end
            end
            if (c >= 10 && c <= 23) begin
                n_checks++;
                if (step !== 1'b0) begin
                    n_fail++;
                    $display("FAIL right_nostep c=%0d: got step=%b want 0", c, step);
                end
            end
            if (c == 24) begin
                n_checks++;
                if (step !== 1'b1) begin
                    n_fail++;
                    $display("FAIL right_resume_step: got step=%b want 1", step);
                end
            end
            if (c == 25) begin
                n_checks++;
                if (data !== 16'h8901) begin
                    n_fail++;
                    $display("FAIL right_resume: got %h want 8901", data);
                end
            end
        end
    endtask

    task automatic test_full_len();
        do_clear();
        ld.delete();
        for (int i = 0; i < 16; i++) ld.push_back(i);
        dir = 1'b0;
        load_msg(1'b0);
        n_checks++;
        if (ready !== 1'b1 || len !== 5'd16) begin
            n_fail++;
            $display("FAIL full_commit: got ready=%b len=%0d want 1 16", ready, len);
        end
        wr_en    = 1'b1;
        wr_digit = 4'h5;
        wr_last  = 1'b1;
        clk_step();
        wr_en   = 1'b0;
        wr_last = 1'b0;
        n_checks++;
        if (len !== 5'd16 || data !== 16'h0123) begin
            n_fail++;
            $display("FAIL full_extra_write: got len=%0d data=%h want 16 0123", len, data);
        end
        run = 1'b1;
        clk_step();
        for (int c = 1; c <= 66; c++) begin
            clk_step();
            n_checks++;
            if ({data, len, ready, step} !== {m_data, model_len(), m_committed, m_step}) begin
                n_fail++;
                $display("FAIL full_model c=%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, data, len, ready, step, m_data, model_len(), m_committed, m_step);
            end
            if (c == 61) begin
                n_checks++;
                if (data !== 16'hF012) begin
                    n_fail++;
                    $display("FAIL full_wrap_a: got %h want F012", data);
                end
            end
            if (c == 65) begin
                n_checks++;
                if (data !== 16'h0123) begin
                    n_fail++;
                    $display("FAIL full_wrap_b: got %h want 0123", data);
                end
            end
        end
    endtask

    task automatic test_short_msg();
        do_clear();
        ld.delete();
        ld.push_back(10);
        ld.push_back(11);
        dir = 1'b0;
        load_msg(1'b1);
        clk_step();
        n_checks++;
        if (data !== 16'hABAB || len !== 5'd2) begin
            n_fail++;
            $display("FAIL short_ab: got data=%h len=%0d want ABAB 2", data, len);
        end
        run = 1'b1;
        clk_step();
        for (int c = 1; c <= 5; c++) begin
            clk_step();
            n_checks++;
            if ({data, len, ready, step} !== {m_data, model_len(), m_committed, m_step}) begin
                n_fail++;
                $display("FAIL short_model c=%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, data, len, ready, step, m_data, model_len(), m_committed, m_step);
            end
        end
        n_checks++;
        if (data !== 16'hBABA) begin
            n_fail++;
            $display("FAIL short_ba: got %h want BABA", data);
        end
        do_clear();
        ld.delete();
        ld.push_back(7);
        load_msg(1'b1);
        clk_step();
        n_checks++;
        if (data !== 16'h7777 || len !== 5'd1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL short_single: got data=%h len=%0d ready=%b want 7777 1 1", data, len, ready);
        end
    endtask

    task automatic test_clear_and_reset();
        do_clear();
        ld.delete();
        for (int i = 1; i <= 6; i++) ld.push_back(i);
        dir = 1'b0;
        load_msg(1'b1);
        run = 1'b1;
        repeat (10) clk_step();
        clear    = 1'b1;
        wr_en    = 1'b1;
        wr_digit = 4'h9;
        wr_last  = 1'b1;
        clk_step();
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        n_checks++;
        if ({data, len, ready, step} !== {16'h0000, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL clear_outputs: got %h/%0d/%b/%b want 0000/0/0/0", data, len, ready, step);
        end
        clk_step();
        n_checks++;
        if (ready !== 1'b0 || data !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear_dropped_write: got ready=%b data=%h want 0 0000", ready, data);
        end
        ld.delete();
        ld.push_back(3);
        ld.push_back(5);
        load_msg(1'b1);
        repeat (6) clk_step();
        n_checks++;
        if ({data, len, ready, step} !== {m_data, model_len(), m_committed, m_step}) begin
            n_fail++;
            $display("FAIL prereset_model: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                     data, len, ready, step, m_data, model_len(), m_committed, m_step);
        end
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({data, len, ready, step} !== {16'h0000, 5'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%0d/%b/%b want 0000/0/0/0", data, len, ready, step);
        end
        run = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_clear();
        for (int c = 0; c < 800; c++) begin
            clear    = ($urandom_range(0, 63) == 0);
            wr_en    = ($urandom_range(0, 1) == 1);
            wr_last  = ($urandom_range(0, 4) == 0);
            wr_digit = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) run = ~run;
            dir = 1'($urandom_range(0, 1));
            clk_step();
            n_checks++;
            if ({data, len, ready, step} !== {m_data, model_len(), m_committed, m_step}) begin
                n_fail++;
                $display("FAIL random_model c=%0d: got %h/%0d/%b/%b want %h/%0d/%b/%b",
                         c, data, len, ready, step, m_data, model_len(), m_committed, m_step);
            end
        end
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        run     = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scroll_left();
        test_scroll_right_hold();
        test_full_len();
        test_short_msg();
        test_clear_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
